// File: rtl/rv32i_dmem_mmio.sv
// ============================================================================
// Module      : rv32i_dmem_mmio
// Description : Zero-wait memory-stage slave: word RAM plus GPIO, 64-bit cycle
//               counter, console TX FIFO and sticky W1C status registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_dmem_mmio #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  MemWrite,
  output logic [31:0] ReadDataMTick,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  localparam logic [29:0] WA_GPIO   = 30'h2000_0000;
  localparam logic [29:0] WA_CYC_LO = 30'h2000_0001;
  localparam logic [29:0] WA_CYC_HI = 30'h2000_0002;
  localparam logic [29:0] WA_TX     = 30'h2000_0003;
  localparam logic [29:0] WA_STATUS = 30'h2000_0004;

  logic [1:0]    off;
  logic [29:0]   word;
  logic          is_mmio;
  logic [AW-1:0] ram_idx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          misalign;
  logic          store;
  logic          ram_we;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [31:0]   gpio_q, gpio_d;
  logic [63:0]   cycle_q, cycle_d;
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    status_q, status_d;

  logic          full, empty, pop, push_req, push, overflow;
  logic [1:0]    st_set, st_clr;
  logic [4:0]    cnt5;

  assign off     = ALUResultM[1:0];
  assign word    = ALUResultM[31:2];
  assign is_mmio = ALUResultM[31];
  assign ram_idx = ALUResultM[AW+1:2];

  // Store data is replicated across lanes so the lane enables alone pick the bytes.
  always_comb begin
    be       = 4'b0000;
    wlane    = 32'h0;
    misalign = 1'b0;
    case (MemWrite)
      MW_BYTE: begin
        be    = 4'b0001 << off;
        wlane = {4{WriteDataM[7:0]}};
      end
      MW_HALF: begin
        be       = off[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{WriteDataM[15:0]}};
        misalign = off[0];
      end
      MW_WORD: begin
        be       = 4'b1111;
        wlane    = WriteDataM;
        misalign = (off != 2'b00);
      end
      default: ;
    endcase
  end

  assign store  = (MemWrite != MW_NONE) && !misalign;
  assign ram_we = store && !is_mmio;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && tx_ready;
  assign push_req = store && (word == WA_TX);
  assign push     = push_req && (!full || pop);
  assign overflow = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= WriteDataM[7:0];
  end

  always_comb begin
    gpio_d = gpio_q;
    for (int i = 0; i < 4; i++) begin
      if (store && (word == WA_GPIO) && be[i]) gpio_d[8*i +: 8] = wlane[8*i +: 8];
    end

    // A clearing write lands the counter at 1 so the very next cycle reads 1.
    cycle_d = (store && (word == WA_CYC_LO)) ? 64'd1 : cycle_q + 64'd1;

    wr_ptr_d = push ? wr_ptr_q + FW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // Set events win over a same-edge W1C.
    st_set   = {overflow, (MemWrite != MW_NONE) && misalign};
    st_clr   = (store && (word == WA_STATUS)) ? WriteDataM[1:0] : 2'b00;
    status_d = (status_q & ~st_clr) | st_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_q   <= 32'h0;
      cycle_q  <= 64'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= 2'b00;
    end else begin
      gpio_q   <= gpio_d;
      cycle_q  <= cycle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  assign cnt5 = 5'(count_q);

  always_comb begin
    ReadDataMTick = 32'h0;
    if (!is_mmio) begin
      ReadDataMTick = ram[ram_idx];
    end else begin
      case (word)
        WA_GPIO:   ReadDataMTick = gpio_q;
        WA_CYC_LO: ReadDataMTick = cycle_q[31:0];
        WA_CYC_HI: ReadDataMTick = cycle_q[63:32];
        WA_TX:     ReadDataMTick = {24'h0, cnt5, 1'b0, full, empty};
        WA_STATUS: ReadDataMTick = {30'h0, status_q};
        default:   ReadDataMTick = 32'h0;
      endcase
    end
  end

  assign gpio_out     = gpio_q;
  assign tx_valid     = !empty;
  assign tx_data      = empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign misalign_err = status_q[0];

endmodule

`default_nettype wire

// File: tb/tb_rv32i_dmem_mmio.sv
// ============================================================================
// Module      : tb_rv32i_dmem_mmio
// Description : Randomized + directed bench for rv32i_dmem_mmio against a
//               behavioural model of RAM, MMIO registers and TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_dmem_mmio;

  localparam int RW = 1024;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wd = 32'h0;
  logic [1:0]  mw = 2'b00;
  logic        rdy = 1'b0;
  logic [31:0] rd, gpio;
  logic [7:0]  txd;
  logic        txv, merr;

  always #5 clk = ~clk;

  rv32i_dmem_mmio #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst_n), .ALUResultM(addr), .WriteDataM(wd), .MemWrite(mw),
    .ReadDataMTick(rd), .gpio_out(gpio), .tx_data(txd), .tx_valid(txv),
    .tx_ready(rdy), .misalign_err(merr)
  );

  // Behavioural model state
  logic [31:0]     m_ram [int];
  logic [3:0]      m_vld [int];
  logic [31:0]     m_gpio;
  longint unsigned m_cyc;
  logic [7:0]      q [$];
  logic [1:0]      m_st;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] s_rd, s_gpio;
  logic [7:0]  s_txd;
  logic        s_txv, s_merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkm(input string name, input logic [31:0] act, input logic [31:0] exp,
                      input logic [31:0] mk);
    n_tests++;
    if ((act & mk) !== (exp & mk)) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h mask %08h @%0t", name, act, exp, mk, $time);
    end
  endtask

  function automatic void model_read(input logic [31:0] a, output logic [31:0] e,
                                     output logic [31:0] mk);
    int idx;
    int n;
    e  = 32'h0;
    mk = 32'hFFFF_FFFF;
    if (!a[31]) begin
      idx = int'((a >> 2) % RW);
      mk  = 32'h0;
      if (m_ram.exists(idx)) begin
        e = m_ram[idx];
        for (int b = 0; b < 4; b++) if (m_vld[idx][b]) mk[8*b +: 8] = 8'hFF;
      end
    end else begin
      n = q.size();
      case (a & 32'hFFFF_FFFC)
        32'h8000_0000: e = m_gpio;
        32'h8000_0004: e = m_cyc[31:0];
        32'h8000_0008: e = m_cyc[63:32];
        32'h8000_000C: e = (n * 8) + ((n == FD) ? 2 : 0) + ((n == 0) ? 1 : 0);
        32'h8000_0010: e = {30'h0, m_st};
        default:       e = 32'h0;
      endcase
    end
  endfunction

  function automatic void model_step(input logic [31:0] a, input logic [31:0] w,
                                     input logic [1:0] m, input logic r);
    int          off = int'(a[1:0]);
    bit          bad = (m == 2'd2 && a[0]) || (m == 2'd3 && a[1:0] != 2'd0);
    logic [31:0] wa  = a & 32'hFFFF_FFFC;
    logic [1:0]  set = 2'b00, clr = 2'b00;
    bit          clrcyc = 0, pushreq = 0, pop, was_full;
    logic [3:0]  en = 4'h0;
    logic [31:0] val = 32'h0;
    int          idx;

    for (int b = 0; b < 4; b++) begin
      case (m)
        2'd1: begin en[b] = (b == off); val[8*b +: 8] = w[7:0]; end
        2'd2: begin
          en[b] = (b == off) || (b == off + 1);
          val[8*b +: 8] = (b == off) ? w[7:0] : w[15:8];
        end
        2'd3: begin en[b] = 1'b1; val[8*b +: 8] = w[8*b +: 8]; end
        default: ;
      endcase
    end

    pop      = (q.size() > 0) && r;
    was_full = (q.size() == FD);

    if (m != 2'd0 && bad) begin
      set[0] = 1'b1;
    end else if (m != 2'd0) begin
      if (!a[31]) begin
        idx = int'((a >> 2) % RW);
        if (!m_ram.exists(idx)) begin m_ram[idx] = 32'h0; m_vld[idx] = 4'h0; end
        for (int b = 0; b < 4; b++) if (en[b]) begin
          m_ram[idx][8*b +: 8] = val[8*b +: 8];
          m_vld[idx][b] = 1'b1;
        end
      end else begin
        case (wa)
          32'h8000_0000: for (int b = 0; b < 4; b++) if (en[b]) m_gpio[8*b +: 8] = val[8*b +: 8];
          32'h8000_0004: clrcyc = 1;
          32'h8000_000C: pushreq = 1;
          32'h8000_0010: clr = w[1:0];
          default: ;
        endcase
      end
    end

    if (pop) void'(q.pop_front());
    if (pushreq) begin
      if (!was_full || pop) q.push_back(w[7:0]);
      else set[1] = 1'b1;
    end
    m_st  = (m_st & ~clr) | set;
    m_cyc = clrcyc ? 64'd1 : m_cyc + 64'd1;
  endfunction

  // One clock: apply inputs, compare at the falling edge, advance the model.
  task automatic cyc(input logic [31:0] a, input logic [31:0] w, input logic [1:0] m,
                     input logic r);
    logic [31:0] e, mk;
    addr = a; wd = w; mw = m; rdy = r;
    @(negedge clk);
    s_rd = rd; s_gpio = gpio; s_txd = txd; s_txv = txv; s_merr = merr;
    model_read(a, e, mk);
    chkm("read", rd, e, mk);
    chk("gpio_out", gpio, m_gpio);
    chk("tx_valid", {31'h0, txv}, {31'h0, q.size() > 0});
    chk("tx_data", {24'h0, txd}, {24'h0, (q.size() > 0) ? q[0] : 8'h00});
    chk("misalign_err", {31'h0, merr}, {31'h0, m_st[0]});
    model_step(a, w, m, r);
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; checks the asynchronous clear before any edge.
  task automatic do_reset();
    addr = 32'h8000_0004; mw = 2'b00; rdy = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_tx_valid", {31'h0, txv}, 32'h0);
    chk("rst_tx_data", {24'h0, txd}, 32'h0);
    chk("rst_gpio", gpio, 32'h0);
    chk("rst_cycle_lo", rd, 32'h0);
    chk("rst_misalign", {31'h0, merr}, 32'h0);
    m_gpio = 32'h0; m_cyc = 0; q.delete(); m_st = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  exp_b [8];

    #1;
    do_reset();

    // Byte/half/word lane merging in RAM
    cyc(32'h10, 32'hDEAD_BEEF, 2'd3, 1'b0);
    cyc(32'h11, 32'h0000_0055, 2'd1, 1'b0);
    cyc(32'h10, 32'h0, 2'd0, 1'b0);
    chk("lit_sb_merge", s_rd, 32'hDEAD_55EF);
    cyc(32'h12, 32'h0000_1234, 2'd2, 1'b0);
    cyc(32'h10, 32'h0, 2'd0, 1'b0);
    chk("lit_sh_merge", s_rd, 32'h1234_55EF);

    // Misaligned half store is suppressed and flagged; W1C clears it
    cyc(32'h13, 32'h0000_BEEF, 2'd2, 1'b0);
    cyc(32'h10, 32'h0, 2'd0, 1'b0);
    chk("lit_misalign_set", {31'h0, s_merr}, 32'h1);
    chk("lit_misalign_nowrite", s_rd, 32'h1234_55EF);
    cyc(32'h8000_0010, 32'h1, 2'd3, 1'b0);
    cyc(32'h8000_0010, 32'h0, 2'd0, 1'b0);
    chk("lit_misalign_w1c", {31'h0, s_merr}, 32'h0);

    // Overflow on the ninth push with the sink stalled
    for (int i = 1; i <= 9; i++) cyc(32'h8000_000C, i, 2'd1, 1'b0);
    cyc(32'h8000_0010, 32'h0, 2'd0, 1'b0);
    chk("lit_overflow_status", s_rd, 32'h2);
    cyc(32'h8000_000C, 32'h0, 2'd0, 1'b0);
    chk("lit_tx_full", s_rd, 32'h42);
    for (int i = 1; i <= 8; i++) begin
      cyc(32'h0, 32'h0, 2'd0, 1'b1);
      chk("lit_drain_byte", {24'h0, s_txd}, i);
    end
    cyc(32'h0, 32'h0, 2'd0, 1'b1);
    chk("lit_drain_empty", {31'h0, s_txv}, 32'h0);
    cyc(32'h8000_0010, 32'h2, 2'd3, 1'b0);

    // Push into a full FIFO while it pops: accepted, no overflow
    for (int i = 0; i < 8; i++) cyc(32'h8000_000C, 32'h11 + i, 2'd1, 1'b0);
    cyc(32'h8000_000C, 32'hAA, 2'd1, 1'b1);
    cyc(32'h8000_000C, 32'h0, 2'd0, 1'b0);
    chk("lit_full_push_pop", s_rd, 32'h42);
    cyc(32'h8000_0010, 32'h0, 2'd0, 1'b0);
    chk("lit_no_overflow", s_rd, 32'h0);
    exp_b = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hAA};
    for (int i = 0; i < 8; i++) begin
      cyc(32'h0, 32'h0, 2'd0, 1'b1);
      chk("lit_order", {24'h0, s_txd}, {24'h0, exp_b[i]});
    end

    // Counter clear then count-up
    cyc(32'h8000_0004, 32'h0, 2'd3, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc(32'h8000_0004, 32'h0, 2'd0, 1'b0);
      chk("lit_cycle_lo", s_rd, k);
    end

    // Reset mid-drain: MMIO clears, RAM survives
    cyc(32'h8000_0000, 32'hCAFE_F00D, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) cyc(32'h8000_000C, 32'h31 + i, 2'd1, 1'b0);
    cyc(32'h0, 32'h0, 2'd0, 1'b1);
    do_reset();
    cyc(32'h10, 32'h0, 2'd0, 1'b0);
    chk("lit_ram_retained", s_rd, 32'h1234_55EF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = $urandom & 32'h7FFF_F03F;
        4, 5, 6, 7, 8: a = 32'h8000_0000 + ($urandom_range(0, 5) * 4) + $urandom_range(0, 3);
        default: a = 32'h8000_0000 | $urandom;
      endcase
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc(a, $urandom, ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
          ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
